// File: rtl/s00_axi_ram_slave.sv
// rtl/s00_axi_ram_slave.sv - AXI4 burst slave backed by a word-addressed on-chip RAM
module s00_axi_ram_slave #(
  parameter int          C_S00_AXI_ID_WIDTH   = 1,
  parameter int          C_S00_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_S00_AXI_BASE_ADDR  = 32'h40000000,
  parameter int          C_MEM_WORDS          = 1024
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]   s00_axi_awid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_awaddr,
  input  logic [7:0]                      s00_axi_awlen,
  input  logic [1:0]                      s00_axi_awburst,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [31:0]                     s00_axi_wdata,
  input  logic [3:0]                      s00_axi_wstrb,
  input  logic                            s00_axi_wlast,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]   s00_axi_bid,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S00_AXI_ID_WIDTH-1:0]   s00_axi_arid,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0] s00_axi_araddr,
  input  logic [7:0]                      s00_axi_arlen,
  input  logic [1:0]                      s00_axi_arburst,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S00_AXI_ID_WIDTH-1:0]   s00_axi_rid,
  output logic [31:0]                     s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rlast,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready
);

  localparam int AW = C_S00_AXI_ADDR_WIDTH;
  localparam int IW = (C_MEM_WORDS > 1) ? $clog2(C_MEM_WORDS) : 1;
  localparam logic [AW-1:0] BASE = AW'(C_S00_AXI_BASE_ADDR);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;

  state_t state, state_nxt;

  logic [31:0] mem [C_MEM_WORDS];

  // Round-robin pointer: 0 favours the write channel on the next tie.
  logic rr_read;

  logic [C_S00_AXI_ID_WIDTH-1:0] wr_id, rd_id;
  logic [AW-1:0]                 wr_addr, rd_addr;
  logic [7:0]                    wr_len, rd_len, wr_cnt, rd_cnt;
  logic [1:0]                    wr_burst, rd_burst;
  logic                          wr_err;

  logic aw_hs, ar_hs, w_hs, r_hs;
  logic wr_beat_ok;
  logic [AW-1:0] rd_addr_nxt;
  logic [1:0]    rd_burst_nxt;
  logic          rd_ok_nxt;
  logic [IW-1:0] rd_idx_nxt, wr_idx;

  // A beat is served only when its word lies inside [BASE, BASE + 4*C_MEM_WORDS);
  // addresses past the end never wrap back to BASE.
  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >= BASE) && (((a - BASE) >> 2) < AW'(C_MEM_WORDS));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
    return IW'((a - BASE) >> 2);
  endfunction

  assign aw_hs = s00_axi_awvalid && s00_axi_awready;
  assign ar_hs = s00_axi_arvalid && s00_axi_arready;
  assign w_hs  = s00_axi_wvalid  && s00_axi_wready;
  assign r_hs  = s00_axi_rvalid  && s00_axi_rready;

  assign s00_axi_wready = (state == WR_DATA);
  assign s00_axi_bvalid = (state == WR_RESP);
  assign s00_axi_rvalid = (state == RD_DATA);
  assign s00_axi_bid    = wr_id;
  assign s00_axi_rid    = rd_id;
  assign s00_axi_bresp  = wr_err ? RESP_SLVERR : RESP_OKAY;

  // A write beat is bad if out of range, the burst type is WRAP/reserved, or wlast lies.
  assign wr_beat_ok = in_range(wr_addr) && !wr_burst[1] && (s00_axi_wlast == (wr_cnt == wr_len));
  assign wr_idx     = word_idx(wr_addr);

  // Address of the read beat loaded into the R registers this cycle.
  always_comb begin
    rd_burst_nxt = ar_hs ? s00_axi_arburst : rd_burst;
    if (ar_hs)
      rd_addr_nxt = s00_axi_araddr;
    else if (rd_burst == BURST_INCR)
      rd_addr_nxt = rd_addr + AW'(4);
    else
      rd_addr_nxt = rd_addr;
    rd_ok_nxt  = in_range(rd_addr_nxt) && !rd_burst_nxt[1];
    rd_idx_nxt = word_idx(rd_addr_nxt);
  end

  // State register.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) state <= IDLE;
    else                  state <= state_nxt;
  end

  // Next state and address-channel grants; ready is held low throughout reset.
  always_comb begin
    state_nxt       = state;
    s00_axi_awready = 1'b0;
    s00_axi_arready = 1'b0;
    case (state)
      IDLE: begin
        if (s00_axi_aresetn) begin
          if (s00_axi_awvalid && (!s00_axi_arvalid || !rr_read)) begin
            s00_axi_awready = 1'b1;
            state_nxt       = WR_DATA;
          end else if (s00_axi_arvalid) begin
            s00_axi_arready = 1'b1;
            state_nxt       = RD_DATA;
          end
        end
      end
      WR_DATA: if (w_hs && (wr_cnt == wr_len)) state_nxt = WR_RESP;
      WR_RESP: if (s00_axi_bready)             state_nxt = IDLE;
      RD_DATA: if (r_hs && s00_axi_rlast)      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Burst bookkeeping, arbitration pointer and registered read beat.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rr_read       <= 1'b0;
      wr_id         <= '0;
      wr_addr       <= '0;
      wr_len        <= '0;
      wr_burst      <= '0;
      wr_cnt        <= '0;
      wr_err        <= 1'b0;
      rd_id         <= '0;
      rd_addr       <= '0;
      rd_len        <= '0;
      rd_burst      <= '0;
      rd_cnt        <= '0;
      s00_axi_rdata <= '0;
      s00_axi_rresp <= RESP_OKAY;
      s00_axi_rlast <= 1'b0;
    end else begin
      if (aw_hs) begin
        rr_read  <= 1'b1;
        wr_id    <= s00_axi_awid;
        wr_addr  <= s00_axi_awaddr;
        wr_len   <= s00_axi_awlen;
        wr_burst <= s00_axi_awburst;
        wr_cnt   <= '0;
        wr_err   <= 1'b0;
      end else if (w_hs) begin
        wr_cnt <= wr_cnt + 8'd1;
        if (wr_burst == BURST_INCR) wr_addr <= wr_addr + AW'(4);
        if (!wr_beat_ok) wr_err <= 1'b1;
      end

      if (ar_hs) begin
        rr_read       <= 1'b0;
        rd_id         <= s00_axi_arid;
        rd_addr       <= rd_addr_nxt;
        rd_len        <= s00_axi_arlen;
        rd_burst      <= rd_burst_nxt;
        rd_cnt        <= '0;
        s00_axi_rdata <= rd_ok_nxt ? mem[rd_idx_nxt] : '0;
        s00_axi_rresp <= rd_ok_nxt ? RESP_OKAY : RESP_SLVERR;
        s00_axi_rlast <= (s00_axi_arlen == 8'd0);
      end else if (r_hs) begin
        if (s00_axi_rlast) begin
          s00_axi_rlast <= 1'b0;
        end else begin
          rd_cnt        <= rd_cnt + 8'd1;
          rd_addr       <= rd_addr_nxt;
          s00_axi_rdata <= rd_ok_nxt ? mem[rd_idx_nxt] : '0;
          s00_axi_rresp <= rd_ok_nxt ? RESP_OKAY : RESP_SLVERR;
          s00_axi_rlast <= ((rd_cnt + 8'd1) == rd_len);
        end
      end
    end
  end

  // Byte-enabled RAM write; contents survive reset.
  always_ff @(posedge s00_axi_aclk) begin
    if (w_hs && wr_beat_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (s00_axi_wstrb[b]) mem[wr_idx][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_s00_axi_ram_slave.sv
// tb/tb_s00_axi_ram_slave.sv - directed table-driven bench for s00_axi_ram_slave
module tb_s00_axi_ram_slave;

  localparam logic [31:0] BASE = 32'h40000000;
  localparam logic [1:0]  FIX = 2'b00, INC = 2'b01, WRP = 2'b10;
  localparam logic [1:0]  OK = 2'b00, SLV = 2'b10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [0:0]  awid, bid, arid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;

  s00_axi_ram_slave dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awid(awid), .s00_axi_awaddr(awaddr), .s00_axi_awlen(awlen),
    .s00_axi_awburst(awburst), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wlast(wlast),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bid(bid), .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_arid(arid), .s00_axi_araddr(araddr), .s00_axi_arlen(arlen),
    .s00_axi_arburst(arburst), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rid(rid), .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rlast(rlast), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready)
  );

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_d [256];
  logic [1:0]  exp_r [256];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [3:0]  strb;
    logic [31:0] d0;
    bit          bad_wlast;
    int          err_from;   // -1: all beats OKAY; else first SLVERR beat (writes: any -> SLVERR)
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  task automatic aw_req(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b, input logic [0:0] id);
    int t;
    awaddr = a; awlen = len; awburst = b; awid = id; awvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!awready && t < 50) begin @(negedge clk); t++; end
    chk("aw_grant", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    chk("wready_after_aw", wready, 1);
  endtask

  task automatic ar_req(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b, input logic [0:0] id);
    int t;
    araddr = a; arlen = len; arburst = b; arid = id; arvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!arready && t < 50) begin @(negedge clk); t++; end
    chk("ar_grant", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
    chk("rvalid_after_ar", rvalid, 1);
  endtask

  task automatic w_beats(input logic [31:0] d0, input int nb, input int len, input logic [3:0] strb, input bit bad_wlast);
    int t;
    for (int i = 0; i < nb; i++) begin
      wvalid = 1'b1; wdata = d0 + i; wstrb = strb;
      wlast = bad_wlast ? 1'b0 : (i == len);
      t = 0;
      @(negedge clk);
      while (!wready && t < 50) begin @(negedge clk); t++; end
      chk("w_ready", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic b_wait(input logic [1:0] eresp, input logic [0:0] id, input int hold);
    int t;
    bready = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bvalid && t < 50) begin @(negedge clk); t++; end
    chk("b_valid", bvalid, 1);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("b_hold_valid", bvalid, 1);
      chk("b_hold_resp", bresp, eresp);
    end
    bready = 1'b1;
    chk("b_resp", bresp, eresp);
    chk("b_id", bid, id);
    @(posedge clk); #1 bready = 1'b0;
    chk("b_done", bvalid, 0);
  endtask

  task automatic r_beats(input int len, input logic [0:0] id, input bit rand_rdy);
    int beat, t;
    beat = 0; t = 0;
    while (beat <= len && t < 400) begin
      rready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (rvalid) begin
        chk($sformatf("r_data[%0d]", beat), rdata, exp_d[beat]);
        chk($sformatf("r_resp[%0d]", beat), rresp, exp_r[beat]);
        chk($sformatf("r_last[%0d]", beat), rlast, (beat == len));
        chk("r_id", rid, id);
        if (rready) beat++;
      end
      @(posedge clk); #1;
      t++;
    end
    rready = 1'b0;
    chk("r_beat_count", beat, len + 1);
    chk("r_idle_after_last", rvalid, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_awready"}, awready, 0);
    chk({tag, "_wready"},  wready,  0);
    chk({tag, "_bvalid"},  bvalid,  0);
    chk({tag, "_arready"}, arready, 0);
    chk({tag, "_rvalid"},  rvalid,  0);
    chk({tag, "_rlast"},   rlast,   0);
    chk({tag, "_bresp"},   bresp,   0);
    chk({tag, "_rresp"},   rresp,   0);
  endtask

  initial begin
    vecs[0]  = '{1, BASE,            3, INC, 4'hF, 32'h1,        0, -1};
    vecs[1]  = '{0, BASE,            3, INC, 4'hF, 32'h1,        0, -1};
    vecs[2]  = '{1, BASE + 32'h100,  0, INC, 4'hF, 32'h11223344, 0, -1};
    vecs[3]  = '{1, BASE + 32'h100,  0, INC, 4'h5, 32'hAABBCCDD, 0, -1};
    vecs[4]  = '{0, BASE + 32'h100,  0, INC, 4'hF, 32'h11BB33DD, 0, -1};
    vecs[5]  = '{1, BASE + 32'hFF8,  1, INC, 4'hF, 32'h100,      0, -1};
    vecs[6]  = '{0, BASE + 32'hFFC,  1, INC, 4'hF, 32'h101,      0,  1};
    vecs[7]  = '{1, BASE + 32'h200,  1, INC, 4'hF, 32'h55,       0, -1};
    vecs[8]  = '{1, BASE + 32'h200,  1, WRP, 4'hF, 32'hDEAD0000, 0,  0};
    vecs[9]  = '{0, BASE + 32'h200,  1, INC, 4'hF, 32'h55,       0, -1};
    vecs[10] = '{1, BASE + 32'h300,  2, FIX, 4'hF, 32'h70,       0, -1};
    vecs[11] = '{0, BASE + 32'h300,  2, FIX, 4'hF, 32'h72,       0, -1};
    vecs[12] = '{1, BASE - 32'h4,    0, INC, 4'hF, 32'h77,       0,  0};
    vecs[13] = '{0, BASE - 32'h4,    0, INC, 4'hF, 32'h0,        0,  0};
    vecs[14] = '{0, BASE,            0, WRP, 4'hF, 32'h0,        0,  0};
    vecs[15] = '{1, BASE + 32'h400,  1, INC, 4'hF, 32'h99,       1,  0};
    vecs[16] = '{0, BASE + 32'h400,  0, INC, 4'hF, 32'h99,       0, -1};

    rst_n = 1'b0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    awid = 0; awaddr = 0; awlen = 0; awburst = 0; wdata = 0; wstrb = 0; wlast = 0;
    arid = 0; araddr = 0; arlen = 0; arburst = 0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Simultaneous requests twice: write wins first after reset, then read.
    awaddr = BASE + 32'h500; awlen = 0; awburst = INC; awid = 1; awvalid = 1;
    araddr = BASE + 32'h500; arlen = 0; arburst = INC; arid = 0; arvalid = 1;
    @(negedge clk);
    chk("tie1_awready", awready, 1);
    chk("tie1_arready", arready, 0);
    @(posedge clk); #1 awvalid = 0;
    w_beats(32'hCAFE, 1, 0, 4'hF, 0);
    b_wait(OK, 1, 0);
    awaddr = BASE + 32'h504; awvalid = 1;
    @(negedge clk);
    chk("tie2_arready", arready, 1);
    chk("tie2_awready", awready, 0);
    @(posedge clk); #1 arvalid = 0;
    exp_d[0] = 32'hCAFE; exp_r[0] = OK;
    r_beats(0, 0, 0);
    aw_req(BASE + 32'h504, 0, INC, 1);
    w_beats(32'hBEEF, 1, 0, 4'hF, 0);
    b_wait(OK, 1, 0);

    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        aw_req(vecs[i].addr, vecs[i].len, vecs[i].burst, 1'(i));
        w_beats(vecs[i].d0, int'(vecs[i].len) + 1, int'(vecs[i].len), vecs[i].strb, vecs[i].bad_wlast);
        b_wait((vecs[i].err_from >= 0) ? SLV : OK, 1'(i), 0);
      end else begin
        for (int b = 0; b <= int'(vecs[i].len); b++) begin
          if (vecs[i].err_from >= 0 && b >= vecs[i].err_from) begin
            exp_d[b] = 32'h0; exp_r[b] = SLV;
          end else begin
            exp_d[b] = (vecs[i].burst == FIX) ? vecs[i].d0 : vecs[i].d0 + b;
            exp_r[b] = OK;
          end
        end
        ar_req(vecs[i].addr, vecs[i].len, vecs[i].burst, 1'(i));
        r_beats(int'(vecs[i].len), 1'(i), 0);
      end
    end

    // 16-beat burst: response stalled by bready, read with random rready.
    aw_req(BASE + 32'h700, 15, INC, 0);
    w_beats(32'h1000, 16, 15, 4'hF, 0);
    b_wait(OK, 0, 5);
    for (int b = 0; b < 16; b++) begin exp_d[b] = 32'h1000 + b; exp_r[b] = OK; end
    ar_req(BASE + 32'h700, 15, INC, 1);
    r_beats(15, 1, 1);

    // Reset pulsed while the third write beat is offered.
    aw_req(BASE + 32'h600, 3, INC, 0);
    w_beats(32'hA0, 2, 3, 4'hF, 0);
    wvalid = 1; wdata = 32'hFF; wstrb = 4'hF; wlast = 0;
    awvalid = 1; arvalid = 1;
    rst_n = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(negedge clk);
    chk_reset_outputs("midrst2");
    wvalid = 0; awvalid = 0; arvalid = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 2; b++) begin exp_d[b] = 32'hA0 + b; exp_r[b] = OK; end
    ar_req(BASE + 32'h600, 1, INC, 0);
    r_beats(1, 0, 0);
    aw_req(BASE + 32'h600, 3, INC, 1);
    w_beats(32'hB0, 4, 3, 4'hF, 0);
    b_wait(OK, 1, 0);
    for (int b = 0; b < 4; b++) begin exp_d[b] = 32'hB0 + b; exp_r[b] = OK; end
    ar_req(BASE + 32'h600, 3, INC, 0);
    r_beats(3, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
